jtag_modport: RTL and testbench

JTAG_MODPORT -- requirements
Module: jtag_modport

---
 rtl/jtag_modport_if.sv | 33 +++
 rtl/jtag_modport.sv | 142 ++++++++++++++
 tb/tb_jtag_modport.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/jtag_modport_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_modport_if
// Purpose  : Bundles the JTAG serial pins and the TAP status outputs so the
//            controller and its driver connect through one port.
// Ports    : master -- drives tms/tdi, observes tdo/tdo_en/tap_state/
//                      ir_out/user_dr_out
//            slave  -- the TAP controller side (mirror of master)
// Revision : 1.0  initial release
// ============================================================================
interface jtag_modport_if #(
  parameter int IR_LEN   = 4,
  parameter int USER_LEN = 8
);
  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  logic [3:0]          tap_state;
  logic [IR_LEN-1:0]   ir_out;
  logic [USER_LEN-1:0] user_dr_out;

  modport master (
    output tms, tdi,
    input  tdo, tdo_en, tap_state, ir_out, user_dr_out
  );

  modport slave (
    input  tms, tdi,
    output tdo, tdo_en, tap_state, ir_out, user_dr_out
  );
endinterface
`default_nettype wire

// File: rtl/jtag_modport.sv
`default_nettype none
// ============================================================================
// Module   : jtag_modport
// Purpose  : IEEE 1149.1 style TAP controller with IDCODE, USER and BYPASS
//            data registers.
// Ports    : tck  -- the only clock, all state changes on its rising edge
//            trst -- synchronous active-high reset, beats tms
//            bus  -- jtag_modport_if.slave: tms, tdi in; tdo, tdo_en,
//                    tap_state, ir_out, user_dr_out out
// Revision : 1.0  initial release
// ============================================================================
module jtag_modport #(
  parameter int          IR_LEN     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter int          USER_LEN   = 8
) (
  input  wire logic      tck,
  input  wire logic      trst,
  jtag_modport_if.slave  bus
);

  typedef enum logic [3:0] {
    S_TLR      = 4'd0,
    S_RTI      = 4'd1,
    S_SEL_DR   = 4'd2,
    S_CAP_DR   = 4'd3,
    S_SH_DR    = 4'd4,
    S_EX1_DR   = 4'd5,
    S_PAUSE_DR = 4'd6,
    S_EX2_DR   = 4'd7,
    S_UPD_DR   = 4'd8,
    S_SEL_IR   = 4'd9,
    S_CAP_IR   = 4'd10,
    S_SH_IR    = 4'd11,
    S_EX1_IR   = 4'd12,
    S_PAUSE_IR = 4'd13,
    S_EX2_IR   = 4'd14,
    S_UPD_IR   = 4'd15
  } tap_state_t;

  localparam logic [IR_LEN-1:0] c_ir_idcode  = IR_LEN'(4'b0001);
  localparam logic [IR_LEN-1:0] c_ir_user    = IR_LEN'(4'b0010);
  // Fixed capture pattern; the trailing "01" lets a debugger locate IR
  // boundaries in a scan chain.
  localparam logic [IR_LEN-1:0] c_ir_capture = IR_LEN'(4'b0101);

  tap_state_t          state;
  logic [IR_LEN-1:0]   ir_sh;
  logic [IR_LEN-1:0]   ir_out;
  logic [31:0]         id_sh;
  logic [USER_LEN-1:0] user_sh;
  logic                byp_sh;
  logic [USER_LEN-1:0] user_dr_out;
  logic                tdo;

  // Standard TMS graph.
  function automatic tap_state_t next_of(input tap_state_t s, input logic t);
    case (s)
      S_TLR:      next_of = t ? S_TLR    : S_RTI;
      S_RTI:      next_of = t ? S_SEL_DR : S_RTI;
      S_SEL_DR:   next_of = t ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   next_of = t ? S_EX1_DR : S_SH_DR;
      S_SH_DR:    next_of = t ? S_EX1_DR : S_SH_DR;
      S_EX1_DR:   next_of = t ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: next_of = t ? S_EX2_DR : S_PAUSE_DR;
      S_EX2_DR:   next_of = t ? S_UPD_DR : S_SH_DR;
      S_UPD_DR:   next_of = t ? S_SEL_DR : S_RTI;
      S_SEL_IR:   next_of = t ? S_TLR    : S_CAP_IR;
      S_CAP_IR:   next_of = t ? S_EX1_IR : S_SH_IR;
      S_SH_IR:    next_of = t ? S_EX1_IR : S_SH_IR;
      S_EX1_IR:   next_of = t ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: next_of = t ? S_EX2_IR : S_PAUSE_IR;
      S_EX2_IR:   next_of = t ? S_UPD_IR : S_SH_IR;
      default:    next_of = t ? S_SEL_DR : S_RTI;
    endcase
  endfunction

  // Any code other than IDCODE or USER behaves as BYPASS.
  logic sel_id;
  logic sel_user;
  assign sel_id   = (ir_out == c_ir_idcode);
  assign sel_user = (ir_out == c_ir_user);

  // Register actions are keyed on the state occupied during the edge, so the
  // Capture/Shift/Update work happens on the edge that leaves that state.
  // Pause and Exit states fall through the case and leave data untouched.
  always_ff @(posedge tck) begin
    if (trst) begin
      state       <= S_TLR;
      ir_sh       <= '0;
      ir_out      <= c_ir_idcode;
      id_sh       <= '0;
      user_sh     <= '0;
      byp_sh      <= 1'b0;
      user_dr_out <= '0;
    end else begin
      state <= next_of(state, bus.tms);
      case (state)
        S_CAP_IR: ir_sh <= c_ir_capture;
        S_SH_IR:  ir_sh <= {bus.tdi, ir_sh[IR_LEN-1:1]};
        S_UPD_IR: ir_out <= ir_sh;
        S_CAP_DR: begin
          if (sel_id)        id_sh   <= IDCODE_VAL;
          else if (sel_user) user_sh <= user_dr_out;
          else               byp_sh  <= 1'b0;
        end
        S_SH_DR: begin
          if (sel_id)        id_sh   <= {bus.tdi, id_sh[31:1]};
          else if (sel_user) user_sh <= {bus.tdi, user_sh[USER_LEN-1:1]};
          else               byp_sh  <= bus.tdi;
        end
        S_UPD_DR: begin
          if (sel_user) user_dr_out <= user_sh;
        end
        default: ;
      endcase
      // Falling into Test-Logic-Reset restores the IDCODE instruction; the
      // user data register deliberately survives this.
      if (next_of(state, bus.tms) == S_TLR) ir_out <= c_ir_idcode;
    end
  end

  // tdo shows the bit that the next edge will shift out.
  always_comb begin
    tdo = 1'b0;
    if (state == S_SH_IR) begin
      tdo = ir_sh[0];
    end else if (state == S_SH_DR) begin
      if (sel_id)        tdo = id_sh[0];
      else if (sel_user) tdo = user_sh[0];
      else               tdo = byp_sh;
    end
  end

  assign bus.tdo         = tdo;
  assign bus.tdo_en      = (state == S_SH_IR) || (state == S_SH_DR);
  assign bus.tap_state   = state;
  assign bus.ir_out      = ir_out;
  assign bus.user_dr_out = user_dr_out;

endmodule
`default_nettype wire

// File: tb/tb_jtag_modport.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_modport
// Purpose  : Self-checking bench for jtag_modport: TMS-graph vector table,
//            directed scan sequences and randomized traffic against a
//            behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_jtag_modport;

  logic tck = 1'b0;
  logic trst = 1'b0;
  always #5 tck = ~tck;

  jtag_modport_if #(.IR_LEN(4), .USER_LEN(8)) jif ();

  jtag_modport #(
    .IR_LEN(4), .IDCODE_VAL(32'h1234_5679), .USER_LEN(8)
  ) dut (
    .tck (tck),
    .trst(trst),
    .bus (jif.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // States are plain numbers 0..15; transitions come from a lookup table.
  int nxt [16][2];
  int          m_s;
  logic [3:0]  m_ir, m_ir_sh;
  logic [31:0] m_id;
  logic [7:0]  m_user, m_uout;
  logic        m_byp;

  function automatic int sel_kind();  // 0 idcode, 1 user, 2 bypass
    if (m_ir == 4'd1) return 0;
    if (m_ir == 4'd2) return 1;
    return 2;
  endfunction

  task automatic model_step(input logic t, input logic d, input logic r);
    int ns;
    if (r) begin
      m_s = 0; m_ir = 4'd1; m_ir_sh = 0; m_id = 0; m_user = 0; m_byp = 0; m_uout = 0;
      return;
    end
    ns = nxt[m_s][t];
    if (m_s == 10) m_ir_sh = 4'b0101;
    if (m_s == 11) m_ir_sh = (m_ir_sh >> 1) | (4'(d) << 3);
    if (m_s == 15) m_ir = m_ir_sh;
    if (m_s == 3) begin
      case (sel_kind())
        0: m_id = 32'h1234_5679;
        1: m_user = m_uout;
        default: m_byp = 0;
      endcase
    end
    if (m_s == 4) begin
      case (sel_kind())
        0: m_id = (m_id >> 1) | (32'(d) << 31);
        1: m_user = (m_user >> 1) | (8'(d) << 7);
        default: m_byp = d;
      endcase
    end
    if (m_s == 8 && sel_kind() == 1) m_uout = m_user;
    if (ns == 0) m_ir = 4'd1;
    m_s = ns;
  endtask

  function automatic logic model_tdo();
    if (m_s == 11) return m_ir_sh[0];
    if (m_s == 4) begin
      case (sel_kind())
        0: return m_id[0];
        1: return m_user[0];
        default: return m_byp;
      endcase
    end
    return 1'b0;
  endfunction

  // Drive inputs just after an edge, advance the model, then compare once
  // the next edge has settled.
  task automatic tick(input logic t, input logic d, input logic r);
    jif.tms = t; jif.tdi = d; trst = r;
    model_step(t, d, r);
    @(posedge tck); #1;
    chk("mdl_state", 32'(jif.tap_state), 32'(m_s));
    chk("mdl_tdo",   32'(jif.tdo),       32'(model_tdo()));
    chk("mdl_tdoen", 32'(jif.tdo_en),    32'(m_s == 4 || m_s == 11));
    chk("mdl_ir",    32'(jif.ir_out),    32'(m_ir));
    chk("mdl_user",  32'(jif.user_dr_out), 32'(m_uout));
  endtask

  typedef struct { logic tms; int exp_state; } vec_t;
  vec_t vecs[$];

  initial begin
    logic [31:0] cap;
    logic [7:0]  pat;

    nxt = '{'{1,0}, '{1,2}, '{3,9}, '{4,5}, '{4,5}, '{6,8}, '{6,7}, '{4,8},
            '{1,2}, '{10,0}, '{11,12}, '{11,12}, '{13,15}, '{13,14}, '{11,15}, '{1,2}};
    vecs = '{'{0,1}, '{1,2}, '{0,3}, '{0,4}, '{1,5}, '{0,6}, '{0,6}, '{1,7},
             '{0,4}, '{1,5}, '{1,8}, '{1,2}, '{1,9}, '{0,10}, '{1,12}, '{0,13},
             '{1,14}, '{0,11}, '{1,12}, '{1,15}, '{1,2}, '{0,3}, '{1,5}, '{1,8},
             '{0,1}, '{1,2}, '{1,9}, '{1,0}, '{1,0}, '{0,1}, '{1,2}, '{1,9},
             '{0,10}, '{0,11}, '{1,12}, '{1,15}, '{0,1},
             '{1,2}, '{1,9}, '{1,0}, '{1,0}, '{1,0}, '{0,1}};
    jif.tms = 1'b0; jif.tdi = 1'b0;

    // Reset state.
    tick(0, 0, 1);
    chk("rst_state", 32'(jif.tap_state), 32'd0);
    chk("rst_ir",    32'(jif.ir_out),    32'd1);
    chk("rst_tdoen", 32'(jif.tdo_en),    32'd0);
    chk("rst_tdo",   32'(jif.tdo),       32'd0);
    chk("rst_user",  32'(jif.user_dr_out), 32'd0);

    // TMS graph walk, ending with five ones from RTI then back to RTI.
    foreach (vecs[i]) begin
      tick(vecs[i].tms, 1'($urandom_range(0, 1)), 0);
      chk("tbl_state", 32'(jif.tap_state), 32'(vecs[i].exp_state));
    end

    // IDCODE scan-out after reset.
    tick(0, 0, 1);
    tick(0, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    chk("id_tdoen", 32'(jif.tdo_en), 32'd1);
    for (int i = 0; i < 32; i++) begin
      cap[i] = jif.tdo;
      tick(i == 31, 0, 0);
    end
    chk("idcode", cap, 32'h1234_5679);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    chk("tlr5", 32'(jif.tap_state), 32'd0);

    // IR capture pattern out LSB-first, load BYPASS, then one-cycle delay.
    tick(0, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    cap = '0;
    for (int i = 0; i < 4; i++) begin
      cap[i] = jif.tdo;
      tick(i == 3, 1, 0);
    end
    chk("ir_capture", cap, 32'b0101);
    tick(1, 0, 0); tick(0, 0, 0);
    chk("ir_bypass", 32'(jif.ir_out), 32'hF);
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    chk("byp_first", 32'(jif.tdo), 32'd0);
    pat = 8'b1101_0010;
    for (int i = 0; i < 8; i++) begin
      tick(0, pat[i], 0);
      chk("byp_delay", 32'(jif.tdo), 32'(pat[i]));
    end
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0);

    // USER register write then read back.
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    pat = 8'b0000_0010;
    for (int i = 0; i < 4; i++) tick(i == 3, pat[i], 0);
    tick(1, 0, 0); tick(0, 0, 0);
    chk("ir_user", 32'(jif.ir_out), 32'd2);
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) tick(i == 7, pat[i], 0);
    tick(1, 0, 0); tick(0, 0, 0);
    chk("user_upd", 32'(jif.user_dr_out), 32'hA5);
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    cap = '0;
    for (int i = 0; i < 8; i++) begin
      cap[i] = jif.tdo;
      tick(0, 0, 0);
    end
    chk("user_read", cap, 32'hA5);

    // Reset while still in Shift-DR.
    chk("mid_in_shdr", 32'(jif.tap_state), 32'd4);
    tick(1, 1, 1);
    chk("mid_state", 32'(jif.tap_state), 32'd0);
    chk("mid_tdoen", 32'(jif.tdo_en),    32'd0);
    chk("mid_ir",    32'(jif.ir_out),    32'd1);
    chk("mid_user",  32'(jif.user_dr_out), 32'd0);

    // Randomized traffic, biased toward staying in shift/pause states.
    for (int i = 0; i < 3000; i++) begin
      tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 299) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
